// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data, one transaction in flight.
// Optional FETCH_STARVE_GUARD_EN: after STARVE_LIMIT contended data grants, fetch wins once.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        err
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_D  = 2'd2;
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [31:0]   if_rdata_q, d_rdata_q;
    logic          busy, done, timed_out, can_grant, force_if, gnt_if, gnt_d;

    assign busy      = (state_q != IDLE);
    assign done      = busy & mem_rvalid;
    assign timed_out = busy & ~mem_rvalid & (tmo_q == CW'(TIMEOUT - 1));
    // A completion cycle can hand the port straight to the next winner.
    assign can_grant = (state_q == IDLE) | done;
    assign gnt_d     = can_grant & d_req & ~force_if;
    assign gnt_if    = can_grant & if_req & (~d_req | force_if);

`ifdef FETCH_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;

    assign force_if = if_req & d_req & (starve_q == SW'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (gnt_if)
            starve_d = '0;
        else if (gnt_d & if_req)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`else
    logic [31:0] unused_starve_limit;
    assign unused_starve_limit = 32'(STARVE_LIMIT);
    assign force_if = 1'b0;
`endif

    assign if_gnt    = gnt_if;
    assign d_gnt     = gnt_d;
    assign mem_en    = gnt_if | gnt_d;
    assign mem_we    = gnt_d & d_we;
    assign mem_addr  = gnt_d ? d_addr : if_addr;
    assign mem_wdata = gnt_d ? d_wdata : '0;
    assign mem_size  = gnt_d ? d_size : 2'd2;

    assign if_rvalid = (state_q == BUSY_IF) & mem_rvalid;
    assign d_rvalid  = (state_q == BUSY_D) & mem_rvalid;
    assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    assign d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;
    assign err       = timed_out;
    assign stall     = (if_req & ~gnt_if) | (d_req & ~gnt_d) | (busy & ~mem_rvalid);

    // NOTE: every variable gets a default first so always_comb never infers a latch.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        if (gnt_d) begin
            state_d = BUSY_D;
            tmo_d   = '0;
        end else if (gnt_if) begin
            state_d = BUSY_IF;
            tmo_d   = '0;
        end else if (done | timed_out) begin
            state_d = IDLE;
        end else if (busy) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments; the hold registers are reset because they are visible outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (if_rvalid) if_rdata_q <= mem_rdata;
            if (d_rvalid)  d_rdata_q  <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: grants push expected responses, completions pop and compare.
module tb_mem_arbiter;
    localparam int TMO  = 8;
    localparam int SLIM = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [1:0]  d_size = 2'd2;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall, err;

    typedef struct {
        bit          fetch;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_arbiter #(.STARVE_LIMIT(SLIM), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall(stall), .err(err)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic sb_push(input bit fetch, input bit chk, input logic [31:0] data);
        exp_t e;
        e.fetch = fetch; e.chk = chk; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic sb_compare(input string name, input bit want);
        exp_t e;
        n_tests++;
        if (!want) begin
            if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s: rvalid if=%b d=%b, required none", name, if_rvalid, d_rvalid);
            end
        end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: response expected but scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            if ({if_rvalid, d_rvalid} !== (e.fetch ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL %s: rvalid if/d=%b%b, required fetch=%0b", name, if_rvalid, d_rvalid, e.fetch);
            end else if (e.chk && (e.fetch ? if_rdata : d_rdata) !== e.data) begin
                n_fail++;
                $display("FAIL %s: rdata %h, required %h", name, e.fetch ? if_rdata : d_rdata, e.data);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clock);
        n_tests++;
        if ({if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid, err, stall} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt/en/rvalid/err/stall=%b, required 0", {if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid, err, stall});
        end
        n_tests++;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: if_rdata=%h d_rdata=%h, required 0", if_rdata, d_rdata);
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_single_fetch();
        next_cycle();
        if_req = 1'b1; if_addr = 32'h0100_0000;
        @(negedge clock);
        n_tests++;
        if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 32'h0100_0000 || mem_size !== 2'd2) begin
            n_fail++;
            $display("FAIL fetch_grant: gnt/en/we=%b addr=%h size=%0d, required 1010 01000000 2",
                     {if_gnt, d_gnt, mem_en, mem_we}, mem_addr, mem_size);
        end
        sb_push(1'b1, 1'b1, 32'h0000_0013);
        next_cycle();
        if_req = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({if_gnt, mem_en, if_rvalid, stall} !== 4'b0001) begin
            n_fail++;
            $display("FAIL fetch_busy: gnt/en/rvalid/stall=%b, required 0001", {if_gnt, mem_en, if_rvalid, stall});
        end
        next_cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clock);
        sb_compare("fetch_resp", 1'b1);
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_resp_stall: stall=%b, required 0", stall);
        end
        next_cycle();
        mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clock);
        n_tests++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL fetch_hold: rvalid=%b rdata=%h, required 0 00000013", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_contention();
        next_cycle();
        if_req = 1'b1; if_addr = 32'h0100_0004;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0100; d_size = 2'd2;
        @(negedge clock);
        n_tests++;
        if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b0110 || mem_addr !== 32'h0100_0100 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL contend_grant: gnt/en/we=%b addr=%h stall=%b, required 0110 01000100 1",
                     {if_gnt, d_gnt, mem_en, mem_we}, mem_addr, stall);
        end
        sb_push(1'b0, 1'b1, 32'hCAFE_0001);
        next_cycle();
        d_req = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({if_gnt, d_gnt, mem_en, stall} !== 4'b0001) begin
            n_fail++;
            $display("FAIL contend_busy: gnt/en/stall=%b, required 0001", {if_gnt, d_gnt, mem_en, stall});
        end
        next_cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        @(negedge clock);
        sb_compare("contend_d_resp", 1'b1);
        n_tests++;
        if ({if_gnt, mem_en, mem_we} !== 3'b110 || mem_addr !== 32'h0100_0004 || mem_size !== 2'd2) begin
            n_fail++;
            $display("FAIL contend_b2b: gnt/en/we=%b addr=%h size=%0d, required 110 01000004 2",
                     {if_gnt, mem_en, mem_we}, mem_addr, mem_size);
        end
        sb_push(1'b1, 1'b1, 32'hCAFE_0002);
        next_cycle();
        if_req = 1'b0; mem_rdata = 32'hCAFE_0002;
        @(negedge clock);
        sb_compare("contend_if_resp", 1'b1);
        n_tests++;
        if (d_rdata !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL d_rdata_hold: d_rdata=%h, required cafe0001", d_rdata);
        end
        next_cycle();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0100_0203; d_wdata = 32'hDEAD_BEEF; d_size = 2'd0;
        @(negedge clock);
        n_tests++;
        if ({d_gnt, mem_en, mem_we} !== 3'b111 || mem_wdata !== 32'hDEAD_BEEF || mem_size !== 2'd0 ||
            mem_addr !== 32'h0100_0203) begin
            n_fail++;
            $display("FAIL store_grant: gnt/en/we=%b wdata=%h size=%0d addr=%h, required 111 deadbeef 0 01000203",
                     {d_gnt, mem_en, mem_we}, mem_wdata, mem_size, mem_addr);
        end
        sb_push(1'b0, 1'b0, 32'h0);
        next_cycle();
        d_req = 1'b0; d_we = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
        @(negedge clock);
        sb_compare("store_ack", 1'b1);
        next_cycle();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_timeout();
        if_req = 1'b1; if_addr = 32'h0100_0040;
        @(negedge clock);
        n_tests++;
        if (if_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_grant: if_gnt=%b, required 1", if_gnt);
        end
        next_cycle();
        if_req = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clock);
            sb_compare($sformatf("tmo_c%0d", k), 1'b0);
            n_tests++;
            if (err !== (k == TMO)) begin
                n_fail++;
                $display("FAIL tmo_err_c%0d: err=%b, required %0b", k, err, k == TMO);
            end
            next_cycle();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055;
        @(negedge clock);
        sb_compare("idle_rvalid_ignored", 1'b0);
        n_tests++;
        if (err !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_after: err=%b stall=%b, required 0 0", err, stall);
        end
        next_cycle();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_timeout_edge();
        if_req = 1'b1; if_addr = 32'h0100_0080;
        @(negedge clock);
        sb_push(1'b1, 1'b1, 32'h0000_00AA);
        next_cycle();
        if_req = 1'b0;
        for (int k = 1; k < TMO; k++) begin
            @(negedge clock);
            sb_compare($sformatf("tmo_edge_c%0d", k), 1'b0);
            next_cycle();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_00AA;
        @(negedge clock);
        sb_compare("tmo_edge_resp", 1'b1);
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_edge_err: err=%b, required 0", err);
        end
        next_cycle();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit exp_fetch;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h0100_0000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0100; d_size = 2'd2;
        for (int i = 0; i < 15; i++) begin
            mem_rvalid = (i > 0);
            mem_rdata  = 32'h100 + 32'(i);
            @(negedge clock);
            sb_compare($sformatf("b2b_resp_%0d", i), i > 0);
`ifdef FETCH_STARVE_GUARD_EN
            exp_fetch = ((i % (SLIM + 1)) == SLIM);
`else
            exp_fetch = 1'b0;
`endif
            n_tests++;
            if ({if_gnt, d_gnt} !== {exp_fetch, ~exp_fetch}) begin
                n_fail++;
                $display("FAIL b2b_grant_%0d: if_gnt/d_gnt=%b%b, required %b%b", i, if_gnt, d_gnt, exp_fetch, ~exp_fetch);
            end
            sb_push(exp_fetch, 1'b1, 32'h100 + 32'(i + 1));
            next_cycle();
        end
        if_req = 1'b0; d_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h100 + 32'd15;
        @(negedge clock);
        sb_compare("b2b_drain", 1'b1);
        next_cycle();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0300;
        @(negedge clock);
        next_cycle();
        d_req = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        n_tests++;
        if (d_rdata !== 32'h0 || {d_gnt, mem_en, d_rvalid, err} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: d_rdata=%h gnt/en/rvalid/err=%b, required 0", d_rdata, {d_gnt, mem_en, d_rvalid, err});
        end
        next_cycle();
        reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
        @(negedge clock);
        sb_compare("reset_mid_late_rvalid", 1'b0);
        n_tests++;
        if (d_rdata !== 32'h0 || if_rdata !== 32'h0 || {mem_en, stall, err} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_mid_after: d_rdata=%h if_rdata=%h en/stall/err=%b, required 0",
                     d_rdata, if_rdata, {mem_en, stall, err});
        end
        next_cycle();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_store();
        test_timeout();
        test_timeout_edge();
        test_back_to_back();
        test_reset_mid();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive data grants tolerated while fetch waits (used only when FETCH_STARVE_GUARD_EN is defined).
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles waited for mem_rvalid after an issue.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports if_req input 1, if_addr input 32: instruction-fetch request and byte address.
REQ-006 SHALL have ports if_gnt output 1, if_rvalid output 1, if_rdata output 32: fetch grant, response strobe, response data.
REQ-007 SHALL have ports d_req input 1, d_we input 1, d_addr input 32, d_wdata input 32, d_size input 2: data request, store flag, byte address, store data, access size (0 byte, 1 half, 2 word).
REQ-008 SHALL have ports d_gnt output 1, d_rvalid output 1, d_rdata output 32: data grant, completion strobe, load data.
REQ-009 SHALL have ports mem_en output 1, mem_we output 1, mem_addr output 32, mem_wdata output 32, mem_size output 2: single shared memory port.
REQ-010 SHALL have ports mem_rvalid input 1, mem_rdata input 32: memory completion strobe and read data.
REQ-011 SHALL have ports stall output 1, err output 1: pipeline hold, timeout error pulse.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY_IF, BUSY_D, with exactly one outstanding memory transaction.
REQ-013 SHALL, in IDLE (or the completion cycle per REQ-017) with a request present, combinationally assert the winner's gnt and mem_en in the same cycle, driving mem_* from the winner; mem_we = d_we for data, 0 for fetch; mem_size = 2 for fetch.
REQ-014 SHALL give d_req priority over if_req when both are asserted, except as in REQ-024.
REQ-015 SHALL enter BUSY_IF or BUSY_D on the edge following a grant; no gnt and mem_en=0 while BUSY with no completion.
REQ-016 SHALL, on mem_rvalid in BUSY_IF, pulse if_rvalid for one cycle with if_rdata=mem_rdata; in BUSY_D pulse d_rvalid with d_rdata=mem_rdata (stores included; d_rdata then don't-care).
REQ-017 SHALL allow back-to-back operation: in the mem_rvalid cycle a new grant SHALL be issued per REQ-013/014; next state follows the new winner, else IDLE.
REQ-018 SHALL ignore mem_rvalid in IDLE (no rvalid pulse, no state change).
REQ-019 SHALL count cycles in BUSY; reaching TIMEOUT without mem_rvalid SHALL return to IDLE and pulse err for one cycle with no rvalid pulse; counter clears on every grant.
REQ-020 SHALL drive stall=1 whenever (if_req & ~if_gnt) | (d_req & ~d_gnt), or BUSY with no mem_rvalid that cycle.
REQ-021 SHALL hold if_rdata/d_rdata at their last delivered value between pulses.
REQ-022 SHALL treat deassertion of a request before grant as withdrawal, with no side effect.

Reset
REQ-023 SHALL, on reset, force state IDLE, timeout and starvation counters 0, if_rdata=d_rdata=0, err=0, all rvalid/gnt/mem_en low; reset mid-transaction SHALL abandon it and drop a later mem_rvalid per REQ-018.

Configuration
REQ-024 SHALL, with FETCH_STARVE_GUARD_EN defined, count consecutive data grants made while if_req is asserted; at STARVE_LIMIT the next contended grant SHALL go to fetch and the counter clears (also clears on any fetch grant).
REQ-025 SHALL, without FETCH_STARVE_GUARD_EN, use strict data priority and omit the starvation counter.

Verification
REQ-026 Single fetch: if_req=1, if_addr=0x01000000, mem_rvalid 2 cycles later with 0x00000013 -> if_gnt same cycle, if_rvalid one-cycle pulse, if_rdata=0x00000013, stall high until the pulse.
REQ-027 Contention: if_req=d_req=1, d_we=0, d_addr=0x01000100 in IDLE -> d_gnt first, mem_addr=0x01000100; fetch granted in the d_rvalid cycle.
REQ-028 Store: d_we=1, d_wdata=0xDEADBEEF, d_size=0 -> mem_we=1, mem_wdata=0xDEADBEEF, mem_size=0; d_rvalid on ack.
REQ-029 Timeout: TIMEOUT=8, fetch granted, no mem_rvalid -> err pulse 8 cycles after the grant, state IDLE, no if_rvalid.
REQ-030 Starvation (macro on, STARVE_LIMIT=4): if_req and d_req held high, memory acks in 1 cycle -> exactly 4 data grants then 1 fetch grant, repeating; macro off -> fetch never granted.
REQ-031 Reset mid-op: assert reset in BUSY_D, then mem_rvalid=1 after release -> no d_rvalid, outputs at reset values.
